// File: rtl/ring_johnson_counter.sv
// Ring / Johnson shift counter with direction, enable, parallel load and tc pulse.
// Define RJC_SELF_CORRECT_EN to reinitialise on illegal states and pulse err.
module ring_johnson_counter #(
    parameter int WIDTH = 16,
    localparam int PW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] INIT      = WIDTH'(1);
    localparam logic [PW-1:0]    PH_ONE    = PW'(1);
    localparam logic [PW-1:0]    RING_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    JOHN_LAST = PW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] shift_val;
    logic [PW-1:0]    step_phase;
    logic [PW-1:0]    last_phase;
    logic             wrap;
    logic             legal;

    always_comb begin
        last_phase = mode_q ? JOHN_LAST : RING_LAST;
    end

    // Johnson differs from ring only by inverting the bit wrapped around.
    always_comb begin
        shift_val = out_q;
        unique case ({mode_q, dir})
            2'b00: shift_val = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            2'b01: shift_val = {out_q[0], out_q[WIDTH-1:1]};
            2'b10: shift_val = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
            2'b11: shift_val = {~out_q[0], out_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        wrap       = 1'b0;
        step_phase = phase_q;
        if (!dir) begin
            wrap       = (phase_q == last_phase);
            step_phase = wrap ? '0 : phase_q + PH_ONE;
        end else begin
            wrap       = (phase_q == '0);
            step_phase = wrap ? last_phase : phase_q - PH_ONE;
        end
    end

`ifdef RJC_SELF_CORRECT_EN
    logic [WIDTH-1:0] inv_val;
    logic             err_q, err_d;

    // Johnson states are thermometer codes filled from either end.
    always_comb begin
        inv_val = ~out_q;
        if (mode_q) begin
            legal = ((out_q & (out_q + INIT)) == '0) ||
                    ((inv_val & (inv_val + INIT)) == '0);
        end else begin
            legal = (out_q != '0) &&
                    ((out_q & (out_q - INIT)) == '0);
        end
    end
`else
    always_comb begin
        legal = 1'b1;
    end
`endif

    always_comb begin
        out_d   = out_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        tc_d    = 1'b0;
`ifdef RJC_SELF_CORRECT_EN
        err_d   = 1'b0;
`endif
        if (load) begin
            out_d   = load_val;
            phase_d = '0;
            mode_d  = mode;
        end else if (mode != mode_q) begin
            out_d   = mode ? '0 : INIT;
            phase_d = '0;
            mode_d  = mode;
        end else if (en) begin
            if (!legal) begin
                out_d   = mode_q ? '0 : INIT;
                phase_d = '0;
`ifdef RJC_SELF_CORRECT_EN
                err_d   = 1'b1;
`endif
            end else begin
                out_d   = shift_val;
                phase_d = step_phase;
                tc_d    = wrap;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q   <= INIT;
            phase_q <= '0;
            mode_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            out_q   <= out_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            tc_q    <= tc_d;
        end
    end

`ifdef RJC_SELF_CORRECT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out   = out_q;
    assign phase = phase_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter: WIDTH=16 and WIDTH=2 instances.
// Expected values are hand-derived sequences; checks are immediate assertions.
module tb_ring_johnson_counter;

    logic        clk = 1'b0;
    logic        reset, en, mode, dir, load;
    logic [15:0] load_val;
    logic [15:0] out;
    logic [4:0]  phase;
    logic        tc, err;

    logic        rst2, en2, mode2, dir2, load2;
    logic [1:0]  lv2;
    logic [1:0]  out2;
    logic [1:0]  ph2;
    logic        tc2, err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ring_johnson_counter #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val), .out(out), .phase(phase),
        .tc(tc), .err(err)
    );

    ring_johnson_counter #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(rst2), .en(en2), .mode(mode2), .dir(dir2),
        .load(load2), .load_val(lv2), .out(out2), .phase(ph2),
        .tc(tc2), .err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] o,
                         input logic [4:0] p, input logic t);
        chk({tag, ".out"}, {16'h0, out}, {16'h0, o});
        chk({tag, ".phase"}, {27'h0, phase}, {27'h0, p});
        chk({tag, ".tc"}, {31'h0, tc}, {31'h0, t});
    endtask

    task automatic chk2(input string tag, input logic [1:0] o,
                        input logic [1:0] p, input logic t);
        chk({tag, ".out"}, {30'h0, out2}, {30'h0, o});
        chk({tag, ".phase"}, {30'h0, ph2}, {30'h0, p});
        chk({tag, ".tc"}, {31'h0, tc2}, {31'h0, t});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] e;
        reset = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0;
        load = 1'b0; load_val = 16'h0;
        rst2 = 1'b0; en2 = 1'b0; mode2 = 1'b0; dir2 = 1'b0;
        load2 = 1'b0; lv2 = 2'b00;
        repeat (2) tick();

        chk16("rst", 16'h0001, 5'd0, 1'b0);
        chk("rst.err", {31'h0, err}, 32'h0);

        // ring, up
        reset = 1'b1; en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            e = 32'h1 << (i % 16);
            chk16($sformatf("ring%0d", i), e[15:0], 5'(i % 16), i == 16);
        end

        // Johnson from reset: first edge reinitialises
        mode = 1'b1;
        do_reset();
        tick();
        chk16("jinit", 16'h0000, 5'd0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            e = (i <= 16) ? (32'h1 << i) - 32'h1 : 32'hFFFF << (i - 16);
            chk16($sformatf("john%0d", i), e[15:0], 5'(i % 32), i == 32);
        end
        repeat (3) tick();
        chk16("john35", 16'h0007, 5'd3, 1'b0);
        mode = 1'b0;
        tick();
        chk16("j2ring", 16'h0001, 5'd0, 1'b0);

        // ring, down, then direction flip
        dir = 1'b1;
        do_reset();
        tick();
        chk16("down1", 16'h8000, 5'd15, 1'b1);
        tick();
        chk16("down2", 16'h4000, 5'd14, 1'b0);
        dir = 1'b0;
        tick();
        chk16("flip1", 16'h8000, 5'd15, 1'b0);
        tick();
        chk16("flip2", 16'h0001, 5'd0, 1'b1);

        // load beats en; en=0 holds
        load = 1'b1; load_val = 16'h0F00;
        tick();
        chk16("load", 16'h0F00, 5'd0, 1'b0);
        load = 1'b0; en = 1'b0;
        tick();
        chk16("hold1", 16'h0F00, 5'd0, 1'b0);
        tick();
        chk16("hold2", 16'h0F00, 5'd0, 1'b0);
        en = 1'b1;
        tick();
        chk16("ldstep", 16'h1E00, 5'd1, 1'b0);

        // load also takes mode, without reinit
        load = 1'b1; load_val = 16'h0003; mode = 1'b1;
        tick();
        chk16("ldmode", 16'h0003, 5'd0, 1'b0);
        load = 1'b0;
        tick();
        chk16("ldjstep", 16'h0007, 5'd1, 1'b0);
        mode = 1'b0;
        tick();
        chk16("m2ring", 16'h0001, 5'd0, 1'b0);

        // illegal ring pattern
        load = 1'b1; load_val = 16'h0003; en = 1'b0;
        tick();
        chk16("ld3", 16'h0003, 5'd0, 1'b0);
        chk("ld3.err", {31'h0, err}, 32'h0);
        load = 1'b0; en = 1'b1;
        tick();
`ifdef RJC_SELF_CORRECT_EN
        chk16("ill1", 16'h0001, 5'd0, 1'b0);
        chk("ill1.err", {31'h0, err}, 32'h1);
        tick();
        chk16("ill2", 16'h0002, 5'd1, 1'b0);
        chk("ill2.err", {31'h0, err}, 32'h0);
`else
        chk16("ill1", 16'h0006, 5'd1, 1'b0);
        chk("ill1.err", {31'h0, err}, 32'h0);
        tick();
        chk16("ill2", 16'h000C, 5'd2, 1'b0);
        chk("ill2.err", {31'h0, err}, 32'h0);
`endif

        // async reset between edges
        do_reset();
        repeat (7) tick();
        chk16("pre_rst", 16'h0080, 5'd7, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk16("async_rst", 16'h0001, 5'd0, 1'b0);
        chk("async_rst.err", {31'h0, err}, 32'h0);
        tick();
        chk16("rst_held", 16'h0001, 5'd0, 1'b0);
        reset = 1'b1;

        // WIDTH=2
        chk2("w2rst", 2'b01, 2'd0, 1'b0);
        rst2 = 1'b1; en2 = 1'b1;
        tick();
        chk2("w2r1", 2'b10, 2'd1, 1'b0);
        tick();
        chk2("w2r2", 2'b01, 2'd0, 1'b1);
        mode2 = 1'b1;
        tick();
        chk2("w2jinit", 2'b00, 2'd0, 1'b0);
        tick();
        chk2("w2j1", 2'b01, 2'd1, 1'b0);
        tick();
        chk2("w2j2", 2'b11, 2'd2, 1'b0);
        tick();
        chk2("w2j3", 2'b10, 2'd3, 1'b0);
        tick();
        chk2("w2j4", 2'b00, 2'd0, 1'b1);
        mode2 = 1'b0;
        tick();
        chk2("w2ring", 2'b01, 2'd0, 1'b0);
        dir2 = 1'b1;
        tick();
        chk2("w2d1", 2'b10, 2'd1, 1'b1);
        tick();
        chk2("w2d2", 2'b01, 2'd0, 1'b0);
        chk("w2.err", {31'h0, err2}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
